n_bit_serial_subtractor: RTL
============================

Name: n_bit_serial_subtractor

Overview:
Sequential bit-serial signed subtractor, the inverse-direction companion to n_bit_adder. Computes A - B - bin LSB-first over N cycles using a single full-subtractor cell. Accepts operands through a valid/ready start handshake and returns difference, borrow-out and signed overflow through a valid/ready result handshake. Intended for area-constrained datapaths where one shared 1-bit cell replaces an N-bit ripple subtractor.

Parameters:
N, 8, operand/result width in bits (N >= 2)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start_valid  input  1  operands A, B, bin valid
start_ready  output  1  block can accept operands (high only in IDLE)
A  input  N  minuend, signed two's complement
B  input  N  subtrahend, signed two's complement
bin  input  1  borrow-in
diff  output  N  signed difference A - B - bin (mod 2^N)
bout  output  1  unsigned borrow-out from MSB
ovf  output  1  signed overflow flag
done_valid  output  1  diff/bout/ovf valid
done_ready  input  1  consumer accepts result
busy  output  1  high in RUN or DONE

Behaviour:
- Interface: one clock clk; reset rst_n is asynchronous and active-low.
- Reset (async assert, sync-style release on next edge): state=IDLE; start_ready=1; done_valid=0; busy=0; diff=0; bout=0; ovf=0; internal shift registers, borrow and counter all cleared.
- FSM states: IDLE, RUN, DONE.
- IDLE: start_ready=1. On start_valid && start_ready at a rising edge:
  - capture A into a_sh, B into b_sh, bin into br, A[N-1] and B[N-1] into sign registers;
  - cnt=0; go to RUN.
- RUN: start_ready=0; start_valid ignored (operands not captured). Each cycle uses a0=a_sh[0], b0=b_sh[0]:
  - d = a0 ^ b0 ^ br;
  - br_next = (~a0 & b0) | (~(a0 ^ b0) & br);
  - a_sh and b_sh shift right by 1; d shifts into the MSB of d_sh;
  - cnt increments.
  - On the cycle where cnt == N-1:
    - load diff = completed d_sh, including the final d;
    - bout = br_next;
    - ovf = (sA != sB) && (diff[N-1] != sA);
    - go to DONE.
- DONE: done_valid=1, start_ready=0.
  - diff, bout and ovf are held stable until done_valid && done_ready at an edge, then go to IDLE.
  - New operands are accepted no earlier than the cycle after the result handshake.
- Latency: start accepted at edge k → done_valid high after edge k+N.
- Minimum issue interval: N+2 cycles with done_ready tied high.
- Outputs diff/bout/ovf retain the last result after the handshake until the next completion overwrites them. They are registered; there is no combinational path from inputs.
- Arithmetic identity: {bout,diff} == ({1'b0,A} - {1'b0,B} - bin) mod 2^(N+1), with A and B taken as unsigned bit patterns.
- ovf reflects signed overflow only. bin never affects ovf except through diff.
- Reset mid-RUN or mid-DONE: the operation is aborted immediately, all outputs return to reset values, and no done_valid pulse is produced.
- done_ready high in IDLE or RUN: no effect.
- start_valid held high through DONE: not accepted until IDLE.
- busy = (state != IDLE).

Test Plan:
- N=8, A=5, B=10, bin=0 → after 8 cycles: diff=8'hFB (-5), bout=1, ovf=0. Also check done_valid rises exactly 8 edges after the accept edge.
- A=30, B=-10 (8'hF6), bin=0 → diff=40 (8'h28), bout=1, ovf=0. A=5, B=10, bin=1 → diff=8'hFA (-6), bout=1, ovf=0.
- Overflow corners:
  - A=-128 (8'h80), B=1, bin=0 → diff=8'h7F, bout=0, ovf=1.
  - A=127, B=-1 (8'hFF), bin=0 → diff=8'h80, bout=1, ovf=1.
- Backpressure: hold done_ready=0 for 5 cycles after done_valid while toggling start_valid and operands → diff/bout/ovf stable, start_ready=0, no capture. Raise done_ready → IDLE next cycle, then a new start is accepted.
- Reset mid-RUN: assert rst_n=0 at cnt=3 of A=100, B=-100 → outputs are 0 immediately and start_ready=1 after release. The next operation (A=1, B=1) gives diff=0, bout=0, ovf=0.
- Random: 200 transactions with random A, B, bin and random done_ready stalls → each result satisfies the arithmetic identity. ovf must equal the sign-rule reference.

Source files
------------

// File: rtl/n_bit_serial_subtractor.sv
// Purpose: signed bit-serial subtractor computing A - B - bin LSB-first through one full-subtractor cell.
// Latency: start accepted at edge k -> done_valid high after edge k+N; issue interval N+2 with done_ready high.
// Backpressure: start_ready only in IDLE; result held in DONE until done_valid && done_ready.
module n_bit_serial_subtractor #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start_valid,
    output logic         start_ready,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         bin,
    output logic [N-1:0] diff,
    output logic         bout,
    output logic         ovf,
    output logic         done_valid,
    input  logic         done_ready,
    output logic         busy
);

    localparam int CW = (N > 2) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;

    logic [N-1:0]    a_sh;
    logic [N-1:0]    b_sh;
    logic [N-2:0]    d_sh;     // partial difference; the final bit completes it
    logic            br;
    logic            sign_a;
    logic            sign_b;
    logic [CW-1:0]   cnt;

    logic            a0;
    logic            b0;
    logic            d_bit;
    logic            br_nxt;
    logic [N-1:0]    d_full;
    logic            last;
    logic            start_acc;
    logic            done_acc;

    // Single full-subtractor cell fed from the low bits of the operand shifters
    assign a0        = a_sh[0];
    assign b0        = b_sh[0];
    assign d_bit     = a0 ^ b0 ^ br;
    assign br_nxt    = (~a0 & b0) | (~(a0 ^ b0) & br);
    assign d_full    = {d_bit, d_sh};
    assign last      = (cnt == CW'(N - 1));
    assign start_acc = (state == IDLE) && start_valid;
    assign done_acc  = (state == DONE) && done_ready;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_acc) state_nxt = RUN;
            RUN:     if (last)      state_nxt = DONE;
            DONE:    if (done_acc)  state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    // Handshake and status outputs decoded from the state register
    always_comb begin
        start_ready = 1'b0;
        done_valid  = 1'b0;
        busy        = 1'b1;
        case (state)
            IDLE: begin
                start_ready = 1'b1;
                busy        = 1'b0;
            end
            DONE:    done_valid = 1'b1;
            default: ;
        endcase
    end

    // Operand capture, serial datapath and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh   <= '0;
            b_sh   <= '0;
            d_sh   <= '0;
            br     <= 1'b0;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            cnt    <= '0;
            diff   <= '0;
            bout   <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            if (start_acc) begin
                a_sh   <= A;
                b_sh   <= B;
                br     <= bin;
                sign_a <= A[N-1];
                sign_b <= B[N-1];
                cnt    <= '0;
            end else if (state == RUN) begin
                a_sh <= a_sh >> 1;
                b_sh <= b_sh >> 1;
                d_sh <= d_full[N-1:1];
                br   <= br_nxt;
                cnt  <= cnt + 1'b1;
                if (last) begin
                    diff <= d_full;
                    bout <= br_nxt;
                    // Signed overflow only possible when operand signs differ
                    ovf  <= (sign_a != sign_b) && (d_bit != sign_a);
                end
            end
        end
    end

endmodule
